cache_nway: RTL and testbench

- Parametrised N-way set-associative data cache array with true-LRU replacement, byte/half/word access and write-back victim readout.
- Successor to the fixed 2-way array: way count and geometry are generalised.
- Adds a line-fill state machine that locks the victim way while a multi-word refill is in progress.
- Sits between the pipeline's memory stage and the cache controller FSM, which drives load/store/edit/invalid.

---
 rtl/cache_pkg.sv | 61 ++++++
 rtl/cache_lru.sv | 71 +++++++
 rtl/cache_nway.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_nway.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry defaults, access encodings and fill FSM states
// for the N-way data cache array.
package cache_pkg;

    localparam int ADDR_BITS_DEF = 32;
    localparam int WAYS_DEF = 4;
    localparam int SET_INDEX_WIDTH_DEF = 5;
    localparam int ELEMENT_WORDS_WIDTH_DEF = 2;
    localparam int WORD_BYTES_WIDTH = 2;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_e;

    function automatic logic [31:0] load_extract(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [2:0]  ubhw
    );
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = off[1] ? w[31:16] : w[15:0];
        b = w[{off, 3'b000} +: 8];
        if (ubhw[1])
            r = w;
        else if (ubhw[0])
            r = ubhw[2] ? {16'b0, h} : {{16{h[15]}}, h};
        else
            r = ubhw[2] ? {24'b0, b} : {{24{b[7]}}, b};
        return r;
    endfunction

    function automatic logic [31:0] store_merge(
        input logic [31:0] w,
        input logic [31:0] din,
        input logic [1:0]  off,
        input logic [2:0]  ubhw
    );
        logic [31:0] r;
        r = w;
        if (ubhw[1])
            r = din;
        else if (ubhw[0]) begin
            if (off[1])
                r[31:16] = din[15:0];
            else
                r[15:0] = din[15:0];
        end else
            r[{off, 3'b000} +: 8] = din[7:0];
        return r;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU age store with invalid-first victim selection.
// Age 0 is most recent, WAYS-1 is the replacement candidate.
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS = WAYS_DEF,
    parameter int SET_INDEX_WIDTH = SET_INDEX_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SET_INDEX_WIDTH-1:0] rd_set,
    input  logic [WAYS-1:0]            rd_valid,
    input  logic                       upd_en,
    input  logic [SET_INDEX_WIDTH-1:0] upd_set,
    input  logic [$clog2(WAYS)-1:0]    upd_way,
    input  logic                       clr_en,
    input  logic [SET_INDEX_WIDTH-1:0] clr_set,
    output logic [$clog2(WAYS)-1:0]    victim
);

    localparam int SETS = 1 << SET_INDEX_WIDTH;
    localparam int WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];
    logic [WAY_W-1:0] cur_age;
    logic             found;

    always_comb begin
        age_d = age_q;
        cur_age = age_q[upd_set][upd_way];
        if (clr_en) begin
            for (int w = 0; w < WAYS; w++)
                age_d[clr_set][w] = WAY_W'(w);
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == upd_way)
                    age_d[upd_set][w] = '0;
                else if (age_q[upd_set][w] < cur_age)
                    age_d[upd_set][w] = age_q[upd_set][w] + 1'b1;
            end
        end
    end

    always_comb begin
        found = 1'b0;
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!rd_valid[w] && !found) begin
                victim = WAY_W'(w);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++)
                if (age_q[rd_set][w] == WAY_W'(WAYS - 1))
                    victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative data array with LRU, sized access,
// victim readout and a line-fill FSM that locks the refilled way.
module cache_nway
    import cache_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int WAYS = WAYS_DEF,
    parameter int SET_INDEX_WIDTH = SET_INDEX_WIDTH_DEF,
    parameter int ELEMENT_WORDS_WIDTH = ELEMENT_WORDS_WIDTH_DEF,
    parameter int TAG_BITS = ADDR_BITS - SET_INDEX_WIDTH
                           - ELEMENT_WORDS_WIDTH - WORD_BYTES_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic                    load,
    input  logic                    store,
    input  logic                    edit,
    input  logic                    invalid,
    input  logic [2:0]              u_b_h_w,
    input  logic [31:0]             din,
    output logic                    hit,
    output logic [31:0]             dout,
    output logic                    valid,
    output logic                    dirty,
    output logic [TAG_BITS-1:0]     tag,
    output logic [$clog2(WAYS)-1:0] victim_way,
    output logic                    fill_busy
);

    localparam int SETS = 1 << SET_INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << ELEMENT_WORDS_WIDTH;
    localparam int WAY_W = $clog2(WAYS);
    localparam int CNT_W = ELEMENT_WORDS_WIDTH + 1;
    localparam int SIW = SET_INDEX_WIDTH;
    localparam int EWW = ELEMENT_WORDS_WIDTH;

    logic [TAG_BITS-1:0] a_tag;
    logic [SIW-1:0]      a_set;
    logic [EWW-1:0]      a_word;
    logic [1:0]          a_off;

    assign a_off  = addr[1:0];
    assign a_word = addr[WORD_BYTES_WIDTH +: EWW];
    assign a_set  = addr[WORD_BYTES_WIDTH + EWW +: SIW];
    assign a_tag  = addr[ADDR_BITS-1 -: TAG_BITS];

    logic [31:0]         data_q [SETS][WAYS][LINE_WORDS];
    logic [TAG_BITS-1:0] tag_q  [SETS][WAYS];
    logic [WAYS-1:0]     vbit_q [SETS];
    logic [WAYS-1:0]     vbit_d [SETS];
    logic [WAYS-1:0]     dbit_q [SETS];
    logic [WAYS-1:0]     dbit_d [SETS];

    fill_state_e    state_q, state_d;
    logic [SIW-1:0] fset_q, fset_d;
    logic [WAY_W-1:0] fway_q, fway_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             locked;
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] lru_victim;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] rd_way;

    assign locked  = (state_q == FILL) && (fset_q == a_set);
    assign victim  = locked ? fway_q : lru_victim;
    assign hit_any = |hit_vec;
    assign rd_way  = hit_any ? hit_way : victim;

    // The way under refill is masked even if a stale tag matches.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = vbit_q[a_set][w]
                       && (tag_q[a_set][w] == a_tag)
                       && !(locked && fway_q == WAY_W'(w));
            if (hit_vec[w])
                hit_way = WAY_W'(w);
        end
    end

    logic             wr_en;
    logic [WAY_W-1:0] wr_way;
    logic [31:0]      wr_data;
    logic             tag_we;
    logic             upd_en;
    logic [WAY_W-1:0] upd_way;

    always_comb begin
        state_d = state_q;
        fset_d  = fset_q;
        fway_d  = fway_q;
        cnt_d   = cnt_q;
        vbit_d  = vbit_q;
        dbit_d  = dbit_q;
        wr_en   = 1'b0;
        wr_way  = hit_way;
        wr_data = store_merge(data_q[a_set][hit_way][a_word],
                              din, a_off, u_b_h_w);
        tag_we  = 1'b0;
        upd_en  = (load || edit) && hit_any;
        upd_way = hit_way;
        if (invalid) begin
            vbit_d[a_set] = '0;
            dbit_d[a_set] = '0;
            upd_en = 1'b0;
            if (locked) begin
                state_d = IDLE;
                cnt_d = '0;
            end
        end else if (store) begin
            if (state_q == IDLE) begin
                wr_en   = 1'b1;
                wr_way  = victim;
                wr_data = din;
                tag_we  = 1'b1;
                vbit_d[a_set][victim] = 1'b0;
                dbit_d[a_set][victim] = 1'b0;
                fset_d  = a_set;
                fway_d  = victim;
                cnt_d   = CNT_W'(1);
                state_d = FILL;
            end else if (fset_q == a_set) begin
                wr_en   = 1'b1;
                wr_way  = fway_q;
                wr_data = din;
                cnt_d   = cnt_q + 1'b1;
            end
            if (wr_en && cnt_d == CNT_W'(LINE_WORDS)) begin
                vbit_d[a_set][wr_way] = 1'b1;
                dbit_d[a_set][wr_way] = 1'b0;
                upd_en  = 1'b1;
                upd_way = wr_way;
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (edit && hit_any) begin
            wr_en = 1'b1;
            dbit_d[a_set][hit_way] = 1'b1;
        end
    end

    cache_lru #(
        .WAYS(WAYS),
        .SET_INDEX_WIDTH(SIW)
    ) u_lru (
        .clk(clk),
        .rst_n(rst),
        .rd_set(a_set),
        .rd_valid(vbit_q[a_set]),
        .upd_en(upd_en),
        .upd_set(a_set),
        .upd_way(upd_way),
        .clr_en(invalid),
        .clr_set(a_set),
        .victim(lru_victim)
    );

    logic                hit_d, hit_q;
    logic [31:0]         dout_d, dout_q;
    logic                valid_d, valid_q;
    logic                dirty_d, dirty_q;
    logic [TAG_BITS-1:0] tag_d, tag_q_o;
    logic [WAY_W-1:0]    vic_d, vic_q;

    always_comb begin
        hit_d   = hit_any;
        dout_d  = data_q[a_set][victim][a_word];
        if (load && hit_any)
            dout_d = load_extract(data_q[a_set][hit_way][a_word],
                                  a_off, u_b_h_w);
        valid_d = vbit_q[a_set][rd_way];
        dirty_d = dbit_q[a_set][rd_way];
        tag_d   = tag_q[a_set][rd_way];
        vic_d   = victim;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            data_q[a_set][wr_way][a_word] <= wr_data;
        if (tag_we)
            tag_q[a_set][wr_way] <= a_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                vbit_q[s] <= '0;
                dbit_q[s] <= '0;
            end
            state_q <= IDLE;
            fset_q  <= '0;
            fway_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            tag_q_o <= '0;
            vic_q   <= '0;
        end else begin
            vbit_q  <= vbit_d;
            dbit_q  <= dbit_d;
            state_q <= state_d;
            fset_q  <= fset_d;
            fway_q  <= fway_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q_o <= tag_d;
            vic_q   <= vic_d;
        end
    end

    assign hit        = hit_q;
    assign dout       = dout_q;
    assign valid      = valid_q;
    assign dirty      = dirty_q;
    assign tag        = tag_q_o;
    assign victim_way = vic_q;
    assign fill_busy  = (state_q == FILL);

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: refill, LRU victim, sized edit,
// invalidate/reset aborts and store-over-edit precedence.
module tb_cache_nway;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        edit = 1'b0;
    logic        invalid = 1'b0;
    logic [2:0]  u_b_h_w = LW;
    logic [31:0] din = '0;
    logic        hit;
    logic [31:0] dout;
    logic        valid;
    logic        dirty;
    logic [22:0] tag;
    logic [1:0]  victim_way;
    logic        fill_busy;

    int tests = 0;
    int fails = 0;

    cache_nway dut (
        .clk(clk), .rst(rst), .addr(addr), .load(load),
        .store(store), .edit(edit), .invalid(invalid),
        .u_b_h_w(u_b_h_w), .din(din), .hit(hit), .dout(dout),
        .valid(valid), .dirty(dirty), .tag(tag),
        .victim_way(victim_way), .fill_busy(fill_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && $countones(dut.hit_vec) > 1) begin
            fails++;
            $display("FAIL multi_hit hit_vec=%b required at most one bit", dut.hit_vec);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input int t, input int s, input int w);
        return (32'(t) << 9) | (32'(s) << 4) | (32'(w) << 2);
    endfunction

    // Present one cycle of controls, sample #1 after the edge.
    task automatic step(input logic [31:0] a, input logic ld, input logic st,
                        input logic ed, input logic inv,
                        input logic [2:0] w, input logic [31:0] d);
        addr = a; load = ld; store = st; edit = ed; invalid = inv;
        u_b_h_w = w; din = d;
        @(posedge clk);
        #1;
        load = 1'b0; store = 1'b0; edit = 1'b0; invalid = 1'b0;
    endtask

    task automatic fill_line(input int t, input int s, input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            step(mk(t, s, i), 0, 1, 0, 0, LW, base + 32'(i));
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL rst_hit got=%b exp=0", hit); end
        tests++; if (dout !== 32'h0) begin fails++; $display("FAIL rst_dout got=%h exp=0", dout); end
        rst = 1'b1;
        step(32'h0000_0100, 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL reset_load_hit got=%b exp=0", hit); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_load_valid got=%b exp=0", valid); end
        tests++; if (victim_way !== 2'd0) begin fails++; $display("FAIL reset_victim got=%0d exp=0", victim_way); end
        tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", fill_busy); end
    endtask

    task automatic test_refill;
        logic [3:0] exp_busy;
        exp_busy = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            step(32'h0000_1100 + 32'(4 * i), 0, 1, 0, 0, LW, 32'h11 * 32'(i + 1));
            tests++;
            if (fill_busy !== exp_busy[i]) begin
                fails++; $display("FAIL refill_busy%0d got=%b exp=%b", i, fill_busy, exp_busy[i]);
            end
        end
        step(32'h0000_1104, 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b1) begin fails++; $display("FAIL refill_hit got=%b exp=1", hit); end
        tests++; if (dout !== 32'h22) begin fails++; $display("FAIL refill_dout got=%h exp=22", dout); end
        tests++; if (tag !== 23'd8) begin fails++; $display("FAIL refill_tag got=%h exp=8", tag); end
        tests++; if (dirty !== 1'b0) begin fails++; $display("FAIL refill_dirty got=%b exp=0", dirty); end
    endtask

    task automatic test_lru;
        for (int t = 1; t <= 4; t++)
            fill_line(t, 2, 32'(t * 16));
        for (int t = 1; t <= 3; t++) begin
            step(mk(t, 2, 0), 1, 0, 0, 0, LW, 0);
            tests++;
            if (hit !== 1'b1 || dout !== 32'(t * 16)) begin
                fails++; $display("FAIL lru_load%0d hit=%b dout=%h exp hit=1 dout=%h", t, hit, dout, t * 16);
            end
        end
        step(mk(9, 2, 1), 0, 0, 0, 0, LW, 0);
        tests++; if (victim_way !== 2'd3) begin fails++; $display("FAIL lru_victim got=%0d exp=3", victim_way); end
        tests++; if (dout !== 32'h41) begin fails++; $display("FAIL lru_wb_dout got=%h exp=41", dout); end
        tests++; if (tag !== 23'd4) begin fails++; $display("FAIL lru_wb_tag got=%h exp=4", tag); end
        tests++; if (valid !== 1'b1 || hit !== 1'b0) begin fails++; $display("FAIL lru_wb_flags valid=%b hit=%b exp 1/0", valid, hit); end
    endtask

    task automatic test_edit;
        step(32'h0000_1103, 0, 0, 1, 0, LB, 32'h0000_00AB);
        step(32'h0000_1103, 1, 0, 0, 0, LB, 0);
        tests++; if (dout !== 32'hFFFF_FFAB) begin fails++; $display("FAIL edit_lb got=%h exp=ffffffab", dout); end
        tests++; if (dirty !== 1'b1) begin fails++; $display("FAIL edit_dirty got=%b exp=1", dirty); end
        step(32'h0000_1103, 1, 0, 0, 0, LBU, 0);
        tests++; if (dout !== 32'h0000_00AB) begin fails++; $display("FAIL edit_lbu got=%h exp=000000ab", dout); end
        step(32'h0000_1100, 1, 0, 0, 0, LW, 0);
        tests++; if (dout !== 32'hAB00_0011) begin fails++; $display("FAIL edit_lw got=%h exp=ab000011", dout); end
        step(32'h0000_1106, 0, 0, 1, 0, LH, 32'h0000_8001);
        step(32'h0000_1106, 1, 0, 0, 0, LH, 0);
        tests++; if (dout !== 32'hFFFF_8001) begin fails++; $display("FAIL edit_lh got=%h exp=ffff8001", dout); end
        step(32'h0000_1104, 1, 0, 0, 0, LHU, 0);
        tests++; if (dout !== 32'h0000_0022) begin fails++; $display("FAIL edit_lhu_lo got=%h exp=00000022", dout); end
        step(32'h0000_1108, 1, 0, 1, 0, LW, 32'h55);
        tests++; if (dout !== 32'h33) begin fails++; $display("FAIL edit_prewrite got=%h exp=33", dout); end
        step(32'h0000_1108, 1, 0, 0, 0, LW, 0);
        tests++; if (dout !== 32'h55) begin fails++; $display("FAIL edit_postwrite got=%h exp=55", dout); end
    endtask

    task automatic test_abort;
        step(mk(7, 5, 0), 0, 1, 0, 0, LW, 32'h70);
        step(mk(7, 5, 1), 0, 1, 0, 0, LW, 32'h71);
        tests++; if (fill_busy !== 1'b1) begin fails++; $display("FAIL abort_busy_pre got=%b exp=1", fill_busy); end
        step(mk(7, 5, 0), 0, 0, 0, 1, LW, 0);
        tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL abort_busy_post got=%b exp=0", fill_busy); end
        step(mk(7, 5, 0), 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL abort_miss hit=%b valid=%b exp 0/0", hit, valid); end
        step(mk(0, 2, 0), 0, 0, 0, 1, LW, 0);
        step(mk(1, 2, 0), 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b0 || victim_way !== 2'd0) begin fails++; $display("FAIL inv_set hit=%b victim=%0d exp 0/0", hit, victim_way); end
    endtask

    task automatic test_precedence;
        step(mk(7, 6, 0), 0, 1, 0, 0, LW, 32'h60);
        step(32'h0000_110C, 0, 1, 1, 0, LW, 32'hDEAD);
        step(32'h0000_110C, 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b1 || dout !== 32'h44) begin fails++; $display("FAIL store_edit hit=%b dout=%h exp 1/44", hit, dout); end
        tests++; if (dirty !== 1'b1) begin fails++; $display("FAIL store_edit_dirty got=%b exp=1", dirty); end
        step(mk(7, 6, 1), 0, 1, 0, 0, LW, 32'h61);
        step(mk(7, 6, 2), 0, 1, 0, 0, LW, 32'h62);
        tests++; if (fill_busy !== 1'b1) begin fails++; $display("FAIL other_set_cnt busy=%b exp=1", fill_busy); end
        step(mk(7, 6, 3), 0, 1, 0, 0, LW, 32'h63);
        tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL fill_done busy=%b exp=0", fill_busy); end
        step(mk(7, 6, 2), 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b1 || dout !== 32'h62) begin fails++; $display("FAIL fill6_load hit=%b dout=%h exp 1/62", hit, dout); end
    endtask

    task automatic test_reset_mid_fill;
        step(mk(3, 7, 0), 0, 1, 0, 0, LW, 32'h30);
        step(mk(3, 7, 1), 1, 1, 0, 0, LW, 32'h31);
        tests++; if (fill_busy !== 1'b1) begin fails++; $display("FAIL rmf_busy_pre got=%b exp=1", fill_busy); end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({hit, valid, dirty, fill_busy} !== 4'b0 || dout !== 32'h0 ||
            tag !== 23'h0 || victim_way !== 2'd0) begin
            fails++;
            $display("FAIL rmf_async hit=%b valid=%b dirty=%b busy=%b dout=%h tag=%h vic=%0d exp all 0",
                     hit, valid, dirty, fill_busy, dout, tag, victim_way);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        step(mk(3, 7, 0), 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b0 || fill_busy !== 1'b0) begin fails++; $display("FAIL rmf_miss hit=%b busy=%b exp 0/0", hit, fill_busy); end
        step(32'h0000_1104, 1, 0, 0, 0, LW, 0);
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL rmf_old_line hit=%b exp=0", hit); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_lru();
        test_edit();
        test_abort();
        test_precedence();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
